// File: rtl/dso_pkg.sv
// Shared types for the AFE gain engine: channel encoding, pot command byte,
// request record, FSM states and the fixed gain -> wiper code table.
package dso_pkg;

  typedef enum logic [1:0] {CH1 = 2'b00, CH2 = 2'b01, CH3 = 2'b10, CH_ILL = 2'b11} ch_e;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_e;

  typedef struct packed {
    ch_e        ch;
    logic [2:0] gain;
  } cfg_req_t;

  localparam logic [7:0] POT_CMD = 8'h13;

  function automatic logic [7:0] gain2code(input logic [2:0] g);
    logic [7:0] c;
    case (g)
      3'd0:    c = 8'h02;
      3'd1:    c = 8'h05;
      3'd2:    c = 8'h09;
      3'd3:    c = 8'h14;
      3'd4:    c = 8'h28;
      3'd5:    c = 8'h46;
      3'd6:    c = 8'h6B;
      default: c = 8'hDD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/chan_gain_spi_if.sv
// Request/handshake bundle between the command processor and the gain engine.
interface chan_gain_spi_if;
  logic       cfg_vld;
  logic [1:0] cfg_ch;
  logic [2:0] cfg_gain;
  logic       cfg_rdy;
  logic       cfg_done;
  logic       cfg_err;

  modport master (output cfg_vld, cfg_ch, cfg_gain, input  cfg_rdy, cfg_done, cfg_err);
  modport slave  (input  cfg_vld, cfg_ch, cfg_gain, output cfg_rdy, cfg_done, cfg_err);
endinterface

// File: rtl/chan_gain_spi_tx16.sv
// Generic 16-bit SPI mode-0 shifter: load presents din[15] on MOSI, start runs
// 16 SCLK periods (low half then high half), done flags the final clk of period 16.
module spi_tx16 #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        start,
  output logic        sclk,
  output logic        mosi,
  output logic        busy,
  output logic        done
);
  localparam int HALF = SCLK_DIV / 2;
  localparam int DW   = $clog2(SCLK_DIV);

  logic [15:0]   sr_q, sr_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic          act_q, act_d;
  logic          sclk_q, sclk_d;
  logic          div_end;

  assign div_end = (div_q == DW'(SCLK_DIV - 1));
  assign done    = act_q && div_end && (bit_q == 4'd15);

  always_comb begin
    sr_d  = sr_q;
    div_d = div_q;
    bit_d = bit_q;
    act_d = act_q;
    if (load) sr_d = din;
    if (start) begin
      act_d = 1'b1;
      div_d = '0;
      bit_d = '0;
    end else if (act_q) begin
      div_d = div_q + 1'b1;
      if (div_end) begin
        div_d = '0;
        // the wrap is the SCLK fall: advance MOSI, or park it low after bit 15
        if (bit_q == 4'd15) begin
          act_d = 1'b0;
          sr_d  = '0;
        end else begin
          bit_d = bit_q + 4'd1;
          sr_d  = {sr_q[14:0], 1'b0};
        end
      end
    end
    sclk_d = act_d && (div_d >= DW'(HALF));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      div_q  <= '0;
      bit_q  <= '0;
      act_q  <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      div_q  <= div_d;
      bit_q  <= bit_d;
      act_q  <= act_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = sr_q[15];
  assign busy = act_q;

endmodule

// File: rtl/chan_gain_spi.sv
// Gain configuration engine: maps a CFG_GAIN request to a pot wiper code and
// writes {POT_CMD, code} to the selected channel pot over SPI.
module chan_gain_spi #(
  parameter int         SCLK_DIV = 32,
  parameter logic [7:0] POT_CMD  = dso_pkg::POT_CMD
) (
  input  logic           clk,
  input  logic           rst_n,
  chan_gain_spi_if.slave cfg,
  output logic           SCLK,
  output logic           MOSI,
  output logic           ch1_ss_n,
  output logic           ch2_ss_n,
  output logic           ch3_ss_n,
  output logic [2:0]     gain_ch1,
  output logic [2:0]     gain_ch2,
  output logic [2:0]     gain_ch3
);
  import dso_pkg::*;

  localparam int HALF = SCLK_DIV / 2;
  localparam int CW   = $clog2(SCLK_DIV);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  cfg_req_t        req_q, req_d;
  logic [2:0]      ss_n_q, ss_n_d;
  logic            done_q, done_d, err_q, err_d;
  logic [2:0][2:0] gain_q, gain_d;
  logic            tx_load, tx_start, tx_done, tx_busy;
  logic [15:0]     tx_data;
  logic            cnt_end;

  assign cnt_end = (cnt_q == CW'(HALF - 1));
  assign tx_data = {POT_CMD, gain2code(cfg.cfg_gain)};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    req_d    = req_q;
    tx_load  = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cfg.cfg_vld && !tx_busy) begin
          req_d.ch   = ch_e'(cfg.cfg_ch);
          req_d.gain = cfg.cfg_gain;
          // illegal channel skips the frame and just reports through DONE
          if (ch_e'(cfg.cfg_ch) == CH_ILL) state_d = S_DONE;
          else begin
            state_d = S_SETUP;
            tx_load = 1'b1;
          end
        end
      end
      S_SETUP: if (cnt_end) begin
        state_d  = S_SHIFT;
        cnt_d    = '0;
        tx_start = 1'b1;
      end
      S_SHIFT: begin
        cnt_d = '0;
        if (tx_done) state_d = S_HOLD;
      end
      S_HOLD: if (cnt_end) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase

    ss_n_d = 3'b111;
    if (state_d inside {S_SETUP, S_SHIFT, S_HOLD}) begin
      case (req_d.ch)
        CH1:     ss_n_d = 3'b110;
        CH2:     ss_n_d = 3'b101;
        CH3:     ss_n_d = 3'b011;
        default: ss_n_d = 3'b111;
      endcase
    end

    done_d = (state_q == S_DONE);
    err_d  = done_d && (req_q.ch == CH_ILL);
    gain_d = gain_q;
    if (state_q == S_DONE) begin
      case (req_q.ch)
        CH1:     gain_d[0] = req_q.gain;
        CH2:     gain_d[1] = req_q.gain;
        CH3:     gain_d[2] = req_q.gain;
        default: gain_d    = gain_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ss_n_q  <= 3'b111;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      gain_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ss_n_q  <= ss_n_d;
      done_q  <= done_d;
      err_q   <= err_d;
      gain_q  <= gain_d;
    end
  end

  spi_tx16 #(.SCLK_DIV(SCLK_DIV)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_load),
    .din   (tx_data),
    .start (tx_start),
    .sclk  (SCLK),
    .mosi  (MOSI),
    .busy  (tx_busy),
    .done  (tx_done)
  );

  assign cfg.cfg_rdy  = (state_q == S_IDLE) && !tx_busy;
  assign cfg.cfg_done = done_q;
  assign cfg.cfg_err  = err_q;
  assign ch1_ss_n     = ss_n_q[0];
  assign ch2_ss_n     = ss_n_q[1];
  assign ch3_ss_n     = ss_n_q[2];
  assign gain_ch1     = gain_q[0];
  assign gain_ch2     = gain_q[1];
  assign gain_ch3     = gain_q[2];

endmodule

// File: tb/tb_chan_gain_spi.sv
// Directed bench for chan_gain_spi: a pot-side monitor captures frames on SCLK
// rise, the main sequence checks latency, words, selects and gain shadows.
module tb_chan_gain_spi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chan_gain_spi_if cfg();
  logic       SCLK, MOSI, ch1_ss_n, ch2_ss_n, ch3_ss_n;
  logic [2:0] gain_ch1, gain_ch2, gain_ch3;
  logic [2:0] ss;
  assign ss = {ch3_ss_n, ch2_ss_n, ch1_ss_n};

  chan_gain_spi #(.SCLK_DIV(32)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg),
    .SCLK(SCLK), .MOSI(MOSI),
    .ch1_ss_n(ch1_ss_n), .ch2_ss_n(ch2_ss_n), .ch3_ss_n(ch3_ss_n),
    .gain_ch1(gain_ch1), .gain_ch2(gain_ch2), .gain_ch3(gain_ch3)
  );

  int n_chk = 0, n_pass = 0;

  // pot-side monitor
  logic        prev_sclk = 1'b0;
  logic [2:0]  prev_ss = 3'b111;
  logic [15:0] rx = '0, last_rx = '0;
  int          nbits = 0, last_nbits = 0, cur_ch = 0, last_ch = 0;
  int          frames = 0, dones = 0, sclk_edges = 0, ss_low_cyc = 0, multi_sel = 0;

  always @(negedge clk) begin
    prev_sclk <= SCLK;
    prev_ss   <= ss;
    if (SCLK !== prev_sclk) sclk_edges <= sclk_edges + 1;
    if (ss != 3'b111) ss_low_cyc <= ss_low_cyc + 1;
    if ($countones(~ss) > 1) multi_sel <= multi_sel + 1;
    if (prev_ss == 3'b111 && ss != 3'b111) begin
      rx     <= '0;
      nbits  <= 0;
      cur_ch <= !ss[0] ? 0 : (!ss[1] ? 1 : 2);
    end else if (SCLK && !prev_sclk) begin
      rx    <= {rx[14:0], MOSI};
      nbits <= nbits + 1;
    end
    if (prev_ss != 3'b111 && ss == 3'b111) begin
      frames     <= frames + 1;
      last_rx    <= rx;
      last_nbits <= nbits;
      last_ch    <= cur_ch;
    end
    if (cfg.cfg_done) dones <= dones + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] get_gain(input int ch);
    return (ch == 0) ? gain_ch1 : (ch == 1) ? gain_ch2 : gain_ch3;
  endfunction

  task automatic wait_rdy();
    int t = 0;
    while (!cfg.cfg_rdy && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("rdy_wait", cfg.cfg_rdy, 1);
  endtask

  task automatic accept(input logic [1:0] ch, input logic [2:0] g);
    cfg.cfg_vld = 1'b1; cfg.cfg_ch = ch; cfg.cfg_gain = g;
    @(posedge clk); #1;
    cfg.cfg_vld = 1'b0;
    cfg.cfg_ch = 2'($urandom_range(3, 0));
    cfg.cfg_gain = 3'($urandom_range(7, 0));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!cfg.cfg_done && n < 2000);
  endtask

  task automatic frame(input logic [1:0] ch, input logic [2:0] g, input logic [15:0] exp);
    int n;
    wait_rdy();
    accept(ch, g);
    wait_done(n);
    chk($sformatf("latency ch%0d g%0d", ch, g), n, 545);
    chk($sformatf("err ch%0d g%0d", ch, g), cfg.cfg_err, 0);
    chk($sformatf("word ch%0d g%0d", ch, g), last_rx, exp);
    chk($sformatf("nbits ch%0d g%0d", ch, g), last_nbits, 16);
    chk($sformatf("ss_ch ch%0d g%0d", ch, g), last_ch, ch);
    chk($sformatf("gain ch%0d g%0d", ch, g), get_gain(ch), g);
    chk("one_select", multi_sel, 0);
  endtask

  initial begin
    int n, f0, d0, e0, l0;
    cfg.cfg_vld = 1'b0; cfg.cfg_ch = 2'b00; cfg.cfg_gain = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", cfg.cfg_rdy, 1);
    chk("rst_done", cfg.cfg_done, 0);
    chk("rst_err", cfg.cfg_err, 0);
    chk("rst_sclk", SCLK, 0);
    chk("rst_mosi", MOSI, 0);
    chk("rst_ss", ss, 3'b111);
    chk("rst_gains", {gain_ch3, gain_ch2, gain_ch1}, 9'h000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frames on each channel
    frame(2'b00, 3'b000, 16'h1302);
    chk("ch2_idle_t1", gain_ch2, 0);
    frame(2'b01, 3'b001, 16'h1305);
    frame(2'b01, 3'b100, 16'h1328);
    frame(2'b10, 3'b010, 16'h1309);
    frame(2'b10, 3'b111, 16'h13DD);
    chk("ch1_kept", gain_ch1, 0);

    // full table sweep on ch1
    frame(2'b00, 3'd0, 16'h1302);
    frame(2'b00, 3'd1, 16'h1305);
    frame(2'b00, 3'd2, 16'h1309);
    frame(2'b00, 3'd3, 16'h1314);
    frame(2'b00, 3'd4, 16'h1328);
    frame(2'b00, 3'd5, 16'h1346);
    frame(2'b00, 3'd6, 16'h136B);
    frame(2'b00, 3'd7, 16'h13DD);

    // illegal channel
    wait_rdy();
    f0 = frames; e0 = sclk_edges; l0 = ss_low_cyc;
    accept(2'b11, 3'b101);
    wait_done(n);
    chk("ill_latency", n, 1);
    chk("ill_err", cfg.cfg_err, 1);
    @(posedge clk); #1;
    chk("ill_done_pulse", cfg.cfg_done, 0);
    chk("ill_err_pulse", cfg.cfg_err, 0);
    chk("ill_ss_low", ss_low_cyc - l0, 0);
    chk("ill_frames", frames - f0, 0);
    chk("ill_sclk", sclk_edges - e0, 0);
    chk("ill_gains", {gain_ch3, gain_ch2, gain_ch1}, {3'd7, 3'd4, 3'd7});

    // request during SHIFT is dropped
    wait_rdy();
    f0 = frames; d0 = dones;
    accept(2'b00, 3'b011);
    repeat (100) @(posedge clk);
    #1;
    chk("busy_rdy", cfg.cfg_rdy, 0);
    cfg.cfg_vld = 1'b1; cfg.cfg_ch = 2'b10; cfg.cfg_gain = 3'b110;
    @(posedge clk); #1;
    cfg.cfg_vld = 1'b0;
    wait_done(n);
    chk("busy_latency", n + 101, 545);
    repeat (700) @(posedge clk);
    #1;
    chk("busy_dones", dones - d0, 1);
    chk("busy_frames", frames - f0, 1);
    chk("busy_ch", last_ch, 0);
    chk("busy_word", last_rx, 16'h1314);
    chk("busy_gain1", gain_ch1, 3);
    chk("busy_gain3", gain_ch3, 7);

    // reset in the middle of bit 7 (SCLK high half)
    wait_rdy();
    accept(2'b00, 3'b110);
    repeat (16 + 7*32 + 20) @(posedge clk);
    #1;
    chk("pre_rst_sclk", SCLK, 1);
    chk("pre_rst_ss", ss, 3'b110);
    d0 = dones;
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ss", ss, 3'b111);
    chk("abort_sclk", SCLK, 0);
    chk("abort_mosi", MOSI, 0);
    chk("abort_rdy", cfg.cfg_rdy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (700) @(posedge clk);
    #1;
    chk("abort_dones", dones - d0, 0);
    chk("abort_gain1", gain_ch1, 0);
    frame(2'b00, 3'b101, 16'h1346);
    chk("post_gain2", gain_ch2, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
